// File: rtl/lcd_timed_controller_pkg.sv
// Shared types and helpers for the timed HD44780 LCD controller.
// Imported by the RTL and by the bench so both agree on latency.
package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ENABLE,
        HOLD,
        GAP,
        DONE
    } lcd_state_t;

    localparam int RW_BIT = 0;
    localparam int RS_BIT = 1;

    // Cycles from the request being seen in IDLE to the single DONE cycle.
    function automatic int lcd_latency(input int setup_cyc, input int pulse_cyc,
                                       input int hold_cyc, input int gap_cyc,
                                       input int bus_4bit);
        int phase;
        phase = setup_cyc + pulse_cyc + hold_cyc + gap_cyc;
        return (bus_4bit != 0) ? (2 * phase + 1) : (phase + 1);
    endfunction

endpackage

// File: rtl/lcd_timed_controller_if.sv
// Avalon-MM slave port bundle between the Nios II data master and the LCD controller.
interface lcd_timed_controller_if;
    logic [1:0] address;
    logic       read;
    logic       write;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       waitrequest;

    modport master (
        output address, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/lcd_timed_controller_phase_timer.sv
// Loadable down-counter that times each LCD bus phase; zero marks the last cycle.
module lcd_phase_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lcd_timed_controller.sv
// Avalon-MM slave that runs correctly timed HD44780 bus cycles (8-bit or nibble mode),
// stalling the master with waitrequest until the LCD cycle has completed.
module lcd_timed_controller
    import lcd_ctrl_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 12,
    parameter int HOLD_CYC  = 2,
    parameter int GAP_CYC   = 10,
    parameter int BUS_4BIT  = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    lcd_timed_controller_if.slave  bus,
    output logic                   LCD_E,
    output logic                   LCD_RS,
    output logic                   LCD_RW,
    inout  wire  [7:0]             LCD_data
);
    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_HG  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int MAX_CYC = (MAX_SP > MAX_HG) ? MAX_SP : MAX_HG;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    lcd_state_t       state;
    lcd_state_t       state_next;
    logic             timer_load;
    logic [CNT_W-1:0] timer_value;
    logic             timer_zero;
    logic             start;
    logic             set_nibble;
    logic             capture;
    logic             pair_end;
    logic             nibble;
    logic [7:0]       wdata_q;
    logic [7:0]       readdata_q;
    logic             drive_en;

    lcd_phase_timer #(.WIDTH(CNT_W)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            nibble     <= 1'b0;
            wdata_q    <= '0;
            readdata_q <= '0;
            LCD_E      <= 1'b0;
            LCD_RS     <= 1'b0;
            LCD_RW     <= 1'b0;
        end else begin
            state <= state_next;
            LCD_E <= (state_next == ENABLE);
            if (start) begin
                wdata_q <= bus.writedata;
                nibble  <= 1'b0;
                LCD_RS  <= bus.address[RS_BIT];
                LCD_RW  <= bus.address[RW_BIT];
            end
            if (set_nibble) begin
                nibble <= 1'b1;
            end
            // In nibble mode the high half arrives on the first pulse, the low half on the second.
            if (capture) begin
                if (BUS_4BIT != 0) begin
                    if (nibble) begin
                        readdata_q[3:0] <= LCD_data[7:4];
                    end else begin
                        readdata_q[7:4] <= LCD_data[7:4];
                    end
                end else begin
                    readdata_q <= LCD_data;
                end
            end
        end
    end

    always_comb begin
        state_next  = state;
        timer_load  = 1'b0;
        timer_value = '0;
        start       = 1'b0;
        set_nibble  = 1'b0;
        capture     = 1'b0;
        pair_end    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.read || bus.write) begin
                    start       = 1'b1;
                    state_next  = SETUP;
                    timer_load  = 1'b1;
                    timer_value = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (timer_zero) begin
                    state_next  = ENABLE;
                    timer_load  = 1'b1;
                    timer_value = PULSE_LOAD;
                end
            end
            ENABLE: begin
                if (timer_zero) begin
                    capture     = LCD_RW;
                    state_next  = HOLD;
                    timer_load  = 1'b1;
                    timer_value = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (timer_zero) begin
                    if (GAP_CYC != 0) begin
                        state_next  = GAP;
                        timer_load  = 1'b1;
                        timer_value = GAP_LOAD;
                    end else begin
                        pair_end = 1'b1;
                    end
                end
            end
            GAP: begin
                if (timer_zero) begin
                    pair_end = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // End of one full E cycle: either start the low nibble or finish.
        if (pair_end) begin
            if ((BUS_4BIT != 0) && !nibble) begin
                set_nibble  = 1'b1;
                state_next  = SETUP;
                timer_load  = 1'b1;
                timer_value = SETUP_LOAD;
            end else begin
                state_next = DONE;
            end
        end
    end

    assign bus.readdata    = readdata_q;
    assign bus.waitrequest = !reset_n || ((bus.read || bus.write) && (state != DONE));

    assign drive_en = !LCD_RW && ((state == SETUP) || (state == ENABLE) || (state == HOLD));

    if (BUS_4BIT != 0) begin : g_nibble_bus
        logic [3:0] nib_out;
        assign nib_out        = nibble ? wdata_q[3:0] : wdata_q[7:4];
        assign LCD_data[7:4]  = drive_en ? nib_out : 4'bz;
        assign LCD_data[3:0]  = 4'bz;
    end else begin : g_byte_bus
        assign LCD_data = drive_en ? wdata_q : 8'bz;
    end

endmodule

// File: doc/lcd_timed_controller.md
# lcd_timed_controller

Avalon-MM slave that drives an HD44780-compatible character LCD with correctly timed bus cycles. It sits between the Nios II data master and the LCD pins, replacing direct strobe-to-pin wiring. It sequences RS/RW setup, the E pulse, hold and recovery from parameterised cycle counts, and supports 8-bit and 4-bit (nibble) bus modes. The master is stalled with waitrequest until the LCD cycle completes.

## Interface
- SETUP_CYC, 2: cycles RS/RW/data are stable before E rises (tAS); ≥1.
- PULSE_CYC, 12: cycles E is high (PWeh); ≥1.
- HOLD_CYC, 2: cycles RS/RW/data are held after E falls (tAH); ≥1.
- GAP_CYC, 10: recovery cycles after hold, before the next E rise or completion; ≥0, where 0 skips GAP.
- BUS_4BIT, 0: 1 selects nibble mode on LCD_data[7:4].
- clk  in  1  system clock; the only clock.
- reset_n  in  1  reset, synchronous, active-low.
- address  in  2  bit0 selects RW (1 = LCD read); bit1 selects RS (1 = data register).
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- writedata  in  8  byte to the LCD.
- readdata  out  8  byte from the LCD; valid in the DONE cycle.
- waitrequest  out  1  stalls the master until DONE.
- LCD_E  out  1  enable pulse.
- LCD_RS  out  1  register select.
- LCD_RW  out  1  read/write.
- LCD_data  inout  8  LCD data bus.

## Operation
- FSM states: IDLE, SETUP, ENABLE, HOLD, GAP, DONE.
- IDLE: if read|write, the FSM latches address, writedata and nibble=0, then moves to SETUP.
- SETUP (SETUP_CYC cycles) → ENABLE (PULSE_CYC) → HOLD (HOLD_CYC) → GAP (GAP_CYC).
- After GAP, in 4-bit mode with nibble=0: set nibble=1 and go to SETUP. Otherwise go to DONE.
- DONE lasts exactly 1 cycle, then the FSM returns to IDLE. A request is never relaunched from DONE.
- Direction comes from latched address[0]; the read/write strobes only start the transaction.
- If read and write are both asserted, it is one transaction.
- LCD_RS and LCD_RW are registered from the latched address. They hold from SETUP through GAP and keep their last values in IDLE.
- LCD_E is high only in ENABLE. It is registered, so it is glitch-free.
- Data drive, applies only when RW=0 and the state is SETUP, ENABLE or HOLD:
  - 8-bit mode: drive the latched byte.
  - 4-bit mode: drive [7:4] with the high nibble first, then the low nibble.
  - LCD_data[3:0] is always high-Z in 4-bit mode.
  - Outside these states the bus is high-Z.
- Read capture, applies when RW=1: sample LCD_data on the last ENABLE cycle.
  - 8-bit mode: sample the full byte.
  - 4-bit mode: sample [7:4] into readdata[7:4] (nibble 0), then into readdata[3:0] (nibble 1).
- readdata holds its value until the next read capture. It is unchanged by writes.
- waitrequest = (read|write) & (state != DONE), combinational. It is forced to 1 while reset_n=0.

## Timing
- Reset values: state IDLE, LCD_E 0, LCD_RS 0, LCD_RW 0, LCD_data high-Z, readdata 0x00, nibble 0.
- Reset mid-transaction: on the next edge the FSM returns to IDLE, E drops, the bus is released and latched fields clear. The partial LCD cycle is abandoned.
- Request first seen in IDLE at cycle 0. DONE (waitrequest low) falls at cycle N:
  - 8-bit: N = SETUP_CYC + PULSE_CYC + HOLD_CYC + GAP_CYC + 1. Defaults give 27.
  - 4-bit: N = 2·(SETUP_CYC + PULSE_CYC + HOLD_CYC + GAP_CYC) + 1. Defaults give 53.
- Back-to-back: the master may present a new request on cycle N+1, which is sampled in IDLE. Minimum spacing between E rising edges is N+1 cycles.
- Phase counter width: $clog2 of max(parameter)+1. It is loaded on every state entry with count−1 and the state advances at 0. A 0-length GAP is skipped.

## Structure
- Package lcd_ctrl_pkg holds:
  - the FSM state enum;
  - the address bit indices RW_BIT=0 and RS_BIT=1;
  - a function returning the total latency N for given parameters, shared with the bench.
- One sub-module, lcd_phase_timer: a loadable down-counter with a zero flag. The FSM loads it per state.

## Test plan
- 8-bit write, defaults, address=2'b10, writedata=0x41:
  - E high exactly on cycles 3–14, RS=1 and RW=0 from cycle 1.
  - LCD_data=0x41 on cycles 1–16, high-Z from cycle 17.
  - waitrequest low only on cycle 27.
- 8-bit read, address=2'b01, bench LCD model drives 0x80 during E:
  - the bus is never driven by the DUT;
  - readdata=0x80 on cycle 27.
- BUS_4BIT=1, write 0xA5:
  - [7:4]=0xA during the first E pulse, 0x5 during the second;
  - LCD_data[3:0] stays high-Z throughout;
  - DONE on cycle 53.
- BUS_4BIT=1, read, model returns 0x3 then 0xC → readdata=0x3C at DONE.
- Reset at cycle 8 of a write:
  - next edge gives E=0, bus high-Z, IDLE, readdata=0x00;
  - a fresh write afterwards completes with nominal latency.
- Back-to-back writes with GAP_CYC=0, and both strobes held high:
  - exactly two E pulses;
  - E rising edges are 18 cycles apart.
